// File: rtl/mips_rf_pkg.sv
// Shared constants and helpers for the MIPS register file with busy scoreboard.
// Default widths, the hardwired zero register index, and packed-port slicing.
package mips_rf_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 5;
  localparam int REG_ZERO   = 0;

  function automatic int slice_lo(input int idx, input int w);
    return idx * w;
  endfunction

endpackage

// File: rtl/rf_read_port.sv
// One combinational read port: array read, write-through bypass,
// zero-register masking and busy lookup.
module rf_read_port
  import mips_rf_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic [ADDR_W-1:0]                     addr,
  input  logic [2**ADDR_W-1:0][DATA_W-1:0]      regs,
  input  logic [2**ADDR_W-1:0]                  busy,
  input  logic                                  wr_en,
  input  logic [ADDR_W-1:0]                     wr_addr,
  input  logic [DATA_W-1:0]                     wr_data,
  output logic [DATA_W-1:0]                     rd_data,
  output logic                                  rd_busy
);

  logic zero_hit;
  logic byp_hit;

  assign zero_hit = (ZERO_REG != 0)
                 && (addr == ADDR_W'(REG_ZERO));
  // Zero register wins over bypass, keeping the case arms exclusive
  assign byp_hit  = (BYPASS != 0) && wr_en
                 && (wr_addr == addr) && !zero_hit;

  always_comb begin
    rd_data = regs[addr];
    rd_busy = busy[addr];
    unique case (1'b1)
      zero_hit: begin
        rd_data = '0;
        rd_busy = 1'b0;
      end
      byp_hit: begin
        rd_data = wr_data;
        rd_busy = 1'b0;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/reg_file_scoreboard.sv
// Multi-port register file with per-register busy scoreboard
// for RAW/WAW stall decisions between issue and writeback.
module reg_file_scoreboard
  import mips_rf_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_busy,
  input  logic                     wr_en,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic                     rsv_en,
  input  logic [ADDR_W-1:0]        rsv_addr,
  output logic                     rsv_ok,
  input  logic                     flush,
  output logic [2**ADDR_W-1:0]     busy_vec,
  output logic [ADDR_W:0]          busy_cnt
);

  localparam int DEPTH = 2**ADDR_W;

  logic [DEPTH-1:0][DATA_W-1:0] regs;
  logic [DEPTH-1:0]             busy;
  logic [DEPTH-1:0]             busy_nxt;
  logic [ADDR_W:0]              cnt_nxt;
  logic                         wr_zero;
  logic                         rsv_zero;
  logic                         wr_eff;
  logic                         rsv_set;
  logic                         set_inc;
  logic                         clr_dec;

  assign wr_zero  = (ZERO_REG != 0)
                 && (wr_addr == ADDR_W'(REG_ZERO));
  assign rsv_zero = (ZERO_REG != 0)
                 && (rsv_addr == ADDR_W'(REG_ZERO));
  assign wr_eff   = wr_en & ~wr_zero;

  assign rsv_ok  = rsv_en & ~flush
                 & (~busy[rsv_addr]
                    | (wr_en & (wr_addr == rsv_addr))
                    | rsv_zero);
  assign rsv_set = rsv_ok & ~rsv_zero;

  // Same-register release+reserve nets to zero on the count
  assign clr_dec = wr_eff & busy[wr_addr];
  assign set_inc = rsv_set
                 & (~busy[rsv_addr]
                    | (wr_eff & (wr_addr == rsv_addr)));

  always_comb begin
    busy_nxt = busy;
    cnt_nxt  = busy_cnt;
    if (flush) begin
      busy_nxt = '0;
      cnt_nxt  = '0;
    end else begin
      if (wr_eff)  busy_nxt[wr_addr]  = 1'b0;
      if (rsv_set) busy_nxt[rsv_addr] = 1'b1;
      cnt_nxt = busy_cnt
              + (ADDR_W+1)'(set_inc)
              - (ADDR_W+1)'(clr_dec);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      regs     <= '0;
      busy     <= '0;
      busy_cnt <= '0;
    end else begin
      if (wr_eff) regs[wr_addr] <= wr_data;
      busy     <= busy_nxt;
      busy_cnt <= cnt_nxt;
    end
  end

  assign busy_vec = busy;

  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
    rf_read_port #(
      .DATA_W   (DATA_W),
      .ADDR_W   (ADDR_W),
      .ZERO_REG (ZERO_REG),
      .BYPASS   (BYPASS)
    ) u_port (
      .addr    (rd_addr[slice_lo(i, ADDR_W) +: ADDR_W]),
      .regs    (regs),
      .busy    (busy),
      .wr_en   (wr_en),
      .wr_addr (wr_addr),
      .wr_data (wr_data),
      .rd_data (rd_data[slice_lo(i, DATA_W) +: DATA_W]),
      .rd_busy (rd_busy[i])
    );
  end

endmodule

// File: tb/tb_reg_file_scoreboard.sv
// Self-checking bench for reg_file_scoreboard: vector table
// through an expectation queue plus hand-written corner sequences.
module tb_reg_file_scoreboard;

  logic        clk;
  logic        rst_n;
  logic [9:0]  rd_addr;
  logic [63:0] rd_data;
  logic [1:0]  rd_busy;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic        rsv_en;
  logic [4:0]  rsv_addr;
  logic        rsv_ok;
  logic        flush;
  logic [31:0] busy_vec;
  logic [5:0]  busy_cnt;

  int n_chk = 0;
  int n_err = 0;

  reg_file_scoreboard dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .rd_busy  (rd_busy),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .rsv_en   (rsv_en),
    .rsv_addr (rsv_addr),
    .rsv_ok   (rsv_ok),
    .flush    (flush),
    .busy_vec (busy_vec),
    .busy_cnt (busy_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic        re;
    logic [4:0]  ra;
    logic        fl;
    logic [4:0]  a0;
    logic [4:0]  a1;
    logic [31:0] d0;
    logic [31:0] d1;
    logic [1:0]  b;
    logic        ok;
    logic [5:0]  cnt;
    logic [31:0] vec;
  } vec_t;

  vec_t tbl[$];
  vec_t exp_q[$];

  function automatic vec_t mk(
    input logic [31:0] we, wa, wd, re, ra, fl,
    input logic [31:0] a0, a1, d0, d1, b, ok,
    input logic [31:0] cnt, vec);
    vec_t v;
    v.we  = we[0];
    v.wa  = wa[4:0];
    v.wd  = wd;
    v.re  = re[0];
    v.ra  = ra[4:0];
    v.fl  = fl[0];
    v.a0  = a0[4:0];
    v.a1  = a1[4:0];
    v.d0  = d0;
    v.d1  = d1;
    v.b   = b[1:0];
    v.ok  = ok[0];
    v.cnt = cnt[5:0];
    v.vec = vec;
    return v;
  endfunction

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic idle();
    wr_en    = 1'b0;
    wr_addr  = '0;
    wr_data  = '0;
    rsv_en   = 1'b0;
    rsv_addr = '0;
    flush    = 1'b0;
  endtask

  task automatic apply(input int idx, input vec_t v);
    vec_t e;
    @(negedge clk);
    wr_en    = v.we;
    wr_addr  = v.wa;
    wr_data  = v.wd;
    rsv_en   = v.re;
    rsv_addr = v.ra;
    flush    = v.fl;
    rd_addr  = {v.a1, v.a0};
    exp_q.push_back(v);
    #1;
    e = exp_q.pop_front();
    chk($sformatf("v%0d d0", idx), rd_data[31:0], e.d0);
    chk($sformatf("v%0d d1", idx), rd_data[63:32], e.d1);
    chk($sformatf("v%0d busy", idx), 32'(rd_busy), 32'(e.b));
    chk($sformatf("v%0d ok", idx), 32'(rsv_ok), 32'(e.ok));
    @(posedge clk);
    #1;
    chk($sformatf("v%0d cnt", idx), 32'(busy_cnt), 32'(e.cnt));
    chk($sformatf("v%0d vec", idx), busy_vec, e.vec);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n   = 1'b0;
    rd_addr = '0;
    idle();

    //       we wa  wd          re ra fl a0 a1 d0          d1          b  ok cnt vec
    tbl.push_back(mk(1, 5, 'h1234,     0, 0, 0, 5, 6, 'h1234,     0,          0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0,          0, 0, 0, 5, 5, 'h1234,     'h1234,     0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0,          1, 8, 0, 8, 5, 0,          'h1234,     0, 1, 1, 'h100));
    tbl.push_back(mk(0, 0, 0,          1, 8, 0, 8, 5, 0,          'h1234,     1, 0, 1, 'h100));
    tbl.push_back(mk(1, 8, 'hDEADBEEF, 1, 8, 0, 8, 8, 'hDEADBEEF, 'hDEADBEEF, 0, 1, 1, 'h100));
    tbl.push_back(mk(0, 0, 0,          0, 0, 0, 8, 8, 'hDEADBEEF, 'hDEADBEEF, 3, 0, 1, 'h100));
    tbl.push_back(mk(1, 8, 'h55,       0, 0, 0, 8, 5, 'h55,       'h1234,     0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0,          1, 3, 0, 8, 3, 'h55,       0,          0, 1, 1, 'h8));
    tbl.push_back(mk(0, 0, 0,          1, 4, 0, 3, 4, 0,          0,          1, 1, 2, 'h18));
    tbl.push_back(mk(0, 0, 0,          1, 9, 0, 4, 9, 0,          0,          1, 1, 3, 'h218));
    tbl.push_back(mk(1, 4, 7,          1, 10,1, 4, 3, 7,          0,          2, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0,          0, 0, 0, 4, 10,7,          0,          0, 0, 0, 0));
    tbl.push_back(mk(1, 0, 'hFFFFFFFF, 0, 0, 0, 0, 1, 0,          0,          0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0,          1, 0, 0, 0, 0, 0,          0,          0, 1, 0, 0));
    tbl.push_back(mk(1, 1, 'hA,        1, 2, 0, 1, 2, 'hA,        0,          0, 1, 1, 'h4));
    tbl.push_back(mk(1, 2, 'hB,        1, 1, 0, 2, 1, 'hB,        'hA,        0, 1, 1, 'h2));
    tbl.push_back(mk(0, 0, 0,          1, 7, 0, 1, 2, 'hA,        'hB,        1, 1, 2, 'h82));
    tbl.push_back(mk(1, 7, 'h77,       0, 0, 0, 7, 1, 'h77,       'hA,        2, 0, 1, 'h2));
    tbl.push_back(mk(0, 0, 0,          1, 7, 0, 7, 7, 'h77,       'h77,       0, 1, 2, 'h82));

    // Reset and read every register on both ports
    @(posedge clk);
    #1;
    @(negedge clk);
    rst_n = 1'b1;
    chk("rst cnt", 32'(busy_cnt), 32'd0);
    chk("rst vec", busy_vec, 32'd0);
    for (int r = 0; r < 32; r++) begin
      rd_addr = {5'(31 - r), 5'(r)};
      #1;
      chk($sformatf("rst r%0d", r), rd_data[31:0], 32'd0);
      chk($sformatf("rst r%0d p1", 31 - r), rd_data[63:32], 32'd0);
      chk($sformatf("rst busy r%0d", r), 32'(rd_busy), 32'd0);
    end

    foreach (tbl[i]) apply(i, tbl[i]);

    // Mid-run reset with r1/r7 busy overrides concurrent reserve and write
    @(negedge clk);
    rst_n    = 1'b0;
    rsv_en   = 1'b1;
    rsv_addr = 5'd12;
    wr_en    = 1'b1;
    wr_addr  = 5'd13;
    wr_data  = 32'h99;
    @(posedge clk);
    #1;
    chk("mrst cnt", 32'(busy_cnt), 32'd0);
    chk("mrst vec", busy_vec, 32'd0);
    @(negedge clk);
    rst_n   = 1'b1;
    idle();
    rd_addr = {5'd13, 5'd7};
    #1;
    chk("mrst r7", rd_data[31:0], 32'd0);
    chk("mrst r13", rd_data[63:32], 32'd0);
    chk("mrst busy", 32'(rd_busy), 32'd0);

    // Fill the scoreboard: r0 never counts, so the ceiling is 31
    for (int r = 0; r < 32; r++) begin
      @(negedge clk);
      rsv_en   = 1'b1;
      rsv_addr = 5'(r);
      #1;
      chk($sformatf("fill ok r%0d", r), 32'(rsv_ok), 32'd1);
      @(posedge clk);
      #1;
    end
    chk("full cnt", 32'(busy_cnt), 32'd31);
    chk("full vec", busy_vec, 32'hFFFF_FFFE);
    @(negedge clk);
    rsv_addr = 5'd5;
    #1;
    chk("waw ok", 32'(rsv_ok), 32'd0);
    @(posedge clk);
    #1;
    chk("waw cnt", 32'(busy_cnt), 32'd31);

    // Drain by writeback; count must step down to zero
    for (int r = 1; r < 32; r++) begin
      @(negedge clk);
      idle();
      wr_en   = 1'b1;
      wr_addr = 5'(r);
      wr_data = 32'(r);
      @(posedge clk);
      #1;
      if (r == 16)
        chk("drain cnt16", 32'(busy_cnt), 32'd15);
    end
    chk("drain cnt", 32'(busy_cnt), 32'd0);
    chk("drain vec", busy_vec, 32'd0);
    @(negedge clk);
    idle();
    rd_addr = {5'd31, 5'd16};
    #1;
    chk("drain r16", rd_data[31:0], 32'd16);
    chk("drain r31", rd_data[63:32], 32'd31);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/reg_file_scoreboard.md
Name: reg_file_scoreboard

Overview:
Parametrised successor to the single-cycle register file, sized for the pipelined MIPS datapath.
- Register array: synchronous write; asynchronous multi-port read with write-through bypass; optional hardwired zero register.
- Per-register busy scoreboard: issue reserves a destination register, writeback releases it. Decode uses it for RAW/WAW stall decisions.
- Sits between decode/issue and the writeback stage.

Parameters:
- DATA_W, 32, register width in bits.
- ADDR_W, 5, address width; depth = 2**ADDR_W.
- NUM_RD, 2, number of independent read ports.
- ZERO_REG, 1, 1 = register 0 always reads 0, ignores writes and is never busy.
- BYPASS, 1, 1 = same-cycle write data forwarded to matching read ports.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous active-low reset.
- rd_addr  in  NUM_RD*ADDR_W  read addresses; port i uses slice [i*ADDR_W +: ADDR_W].
- rd_data  out  NUM_RD*DATA_W  read data, packed the same way.
- rd_busy  out  NUM_RD  1 = port i's register has a pending (reserved, unwritten) result.
- wr_en  in  1  writeback strobe.
- wr_addr  in  ADDR_W  writeback register.
- wr_data  in  DATA_W  writeback value.
- rsv_en  in  1  issue-stage reservation request.
- rsv_addr  in  ADDR_W  register to reserve.
- rsv_ok  out  1  reservation is accepted this cycle (combinational).
- flush  in  1  clears all busy bits (branch mispredict / exception).
- busy_vec  out  2**ADDR_W  current busy bits, registered.
- busy_cnt  out  ADDR_W+1  number of busy registers, registered.

Behaviour:
- Reset: clk and rst_n are fixed as above (one clock, synchronous active-low reset). On a rising edge with rst_n=0, all registers, busy_vec and busy_cnt go to 0. Reset overrides wr_en, rsv_en and flush in the same cycle. Asserting reset mid-operation discards all pending reservations.
- Write: at a clk edge with wr_en=1, reg[wr_addr] <= wr_data and busy[wr_addr] <= 0. A write to a register that is not busy is legal.
- Read (combinational), default: rd_data_i = reg[rd_addr_i].
- Read with bypass: if BYPASS=1, wr_en=1 and wr_addr==rd_addr_i, then rd_data_i = wr_data and rd_busy_i = 0.
- rd_busy_i otherwise = busy[rd_addr_i].
- ZERO_REG=1, address 0: rd_data_i = 0 and rd_busy_i = 0 always. Writes are ignored. A reservation gives rsv_ok=1 but never sets the bit.
- rsv_ok = rsv_en & ~flush & (~busy[rsv_addr] | (wr_en & wr_addr==rsv_addr) | zero-reg case). Only one outstanding write per register is allowed; WAW is rejected.
- Accepted reservation: busy[rsv_addr] <= 1 at the edge.
- Reservation and write to the same register in the same cycle: the write lands, busy ends at 1 and busy_cnt is unchanged.
- Rejected reservation: no state change; issue must retry next cycle.
- flush=1: all busy bits <= 0 and busy_cnt <= 0. rsv_ok is forced to 0. A concurrent wr_en still updates the array.
- busy_cnt tracks the popcount of busy_vec exactly: +1 on accepted set, -1 on clear of a busy bit, net 0 when both happen together. It never exceeds 2**ADDR_W-ZERO_REG and never underflows.
- Read latency 0 cycles (combinational). Write and reservation effects are visible to non-bypassed reads on the cycle after the edge.

Decomposition:
- Package mips_rf_pkg: default DATA_W/ADDR_W constants, REG_ZERO=0, and the packed-port slice helper function.
- One sub-module, rf_read_port, handles one port's array read, bypass compare, zero-reg masking and busy lookup. It is instantiated NUM_RD times in a generate loop.

Test Plan:
1. Reset, then read r1..r31 on both ports -> all rd_data=0, rd_busy=0, busy_cnt=0.
2. wr_en, r5=0x0000_1234 while port0 reads r5 -> same cycle rd_data0=0x0000_1234 (bypass). Next cycle still 0x0000_1234 with wr_en=0.
3. rsv r8 -> rsv_ok=1, next cycle busy_vec[8]=1, busy_cnt=1, rd_busy for r8=1. A second rsv r8 gives rsv_ok=0 and busy_cnt stays 1.
4. r8 busy, same cycle wr r8=0xDEAD_BEEF and rsv r8 -> rsv_ok=1, busy_vec[8] stays 1, busy_cnt stays 1, reg[8]=0xDEAD_BEEF.
5. Reserve r3, r4, r9 (busy_cnt=3), then flush with wr r4=7 -> busy_cnt=0, reg[4]=7, rsv_ok=0 during flush.
6. ZERO_REG=1: wr r0=0xFFFF_FFFF, then rsv r0 -> rd_data for r0=0, rsv_ok=1, busy_vec[0]=0. Mid-sequence rst_n=0 with r7 busy -> next cycle all busy=0, reg[7]=0.
